// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin two-master to one-slave Wishbone arbiter with grant watchdog.
module l2_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_dat_w,
  output logic [DATA_W-1:0] m0_dat_r,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_dat_w,
  output logic [DATA_W-1:0] m1_dat_r,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_adr,
  output logic [DATA_W-1:0] s_dat_w,
  input  logic [DATA_W-1:0] s_dat_r,
  input  logic              s_ack,
  output logic [1:0]        grant
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  state_t state, state_nx;
  logic rr_last, rr_nx;
  logic [WD_W-1:0] wd_cnt, wd_nx;
  logic req0, req1, sel1, gnt, cyc_g, expire;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      wd_cnt  <= '0;
    end else begin
      state   <= state_nx;
      rr_last <= rr_nx;
      wd_cnt  <= wd_nx;
    end
  // ack beats abort beats watchdog; expiry only counts while the master still holds cyc
  always_comb begin
    req0     = m0_cyc & m0_stb;
    req1     = m1_cyc & m1_stb;
    sel1     = state == GRANT1;
    gnt      = state != IDLE;
    cyc_g    = sel1 ? m1_cyc : m0_cyc;
    expire   = gnt & ~s_ack & cyc_g & (wd_cnt == WD_MAX);
    state_nx = state;
    rr_nx    = rr_last;
    wd_nx    = '0;
    if (!gnt)
      state_nx = req0 & req1 ? (rr_last ? GRANT0 : GRANT1) : req0 ? GRANT0 : req1 ? GRANT1 : IDLE;
    else if (s_ack | expire) begin
      state_nx = IDLE;
      rr_nx    = sel1;
    end else if (!cyc_g)
      state_nx = IDLE;
    else
      wd_nx = wd_cnt + 1'b1;
  end
  assign s_cyc    = gnt & cyc_g;
  assign s_stb    = gnt & (sel1 ? m1_stb : m0_stb);
  assign s_we     = gnt & (sel1 ? m1_we : m0_we);
  assign s_adr    = rst_n ? (sel1 ? m1_adr : m0_adr) : '0;
  assign s_dat_w  = rst_n ? (sel1 ? m1_dat_w : m0_dat_w) : '0;
  assign m0_dat_r = rst_n ? s_dat_r : '0;
  assign m1_dat_r = rst_n ? s_dat_r : '0;
  assign m0_ack   = s_ack & (state == GRANT0);
  assign m1_ack   = s_ack & sel1;
  assign m0_err   = expire & ~sel1;
  assign m1_err   = expire & sel1;
  assign grant    = {sel1, state == GRANT0};
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: table-driven per-cycle vectors plus hand sequences for async reset.
module tb_l2_arbiter;
  logic clk = 0, rst_n = 0;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0, s_ack = 0;
  logic [31:0] m0_adr = 0, m1_adr = 0, s_adr;
  logic [255:0] m0_dat_w = 0, m1_dat_w = 0, s_dat_w, s_dat_r = 0, m0_dat_r, m1_dat_r;
  logic m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we;
  logic [1:0] grant;
  int errors = 0, checks = 0;
  l2_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_w(m0_dat_w),
    .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_w(m1_dat_w),
    .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .grant(grant)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic c0, w0; logic [31:0] a0;
    logic c1, w1; logic [31:0] a1;
    logic ack;
    logic ec, ew; logic [31:0] ea; logic [1:0] eg;
    logic k0, k1, r0, r1;
  } vec_t;
  vec_t tv[$];
  task automatic add(input logic c0, w0, input logic [31:0] a0, input logic c1, w1,
                     input logic [31:0] a1, input logic ack, input logic ec, ew,
                     input logic [31:0] ea, input logic [1:0] eg,
                     input logic k0 = 0, k1 = 0, r0 = 0, r1 = 0);
    vec_t v;
    v = '{c0, w0, a0, c1, w1, a1, ack, ec, ew, ea, eg, k0, k1, r0, r1};
    tv.push_back(v);
  endtask
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic drive(input vec_t v, input int i);
    m0_cyc = v.c0; m0_stb = v.c0; m0_we = v.w0; m0_adr = v.a0; m0_dat_w = {8{v.a0}};
    m1_cyc = v.c1; m1_stb = v.c1; m1_we = v.w1; m1_adr = v.a1;
    m1_dat_w = v.w1 ? {32{8'hA5}} : {8{v.a1}};
    s_ack = v.ack; s_dat_r = {8{32'hD000_0000 | i}};
  endtask
  initial begin
    logic [255:0] exp_dw;
    // reset state with active-looking inputs
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1234; s_ack = 1; s_dat_r = '1;
    #3;
    chk("rst_grant", grant, 0);
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_s_adr", s_adr, 0);
    chk("rst_dat_r", m0_dat_r, 0);
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    @(negedge clk); rst_n = 1;
    // contention after reset and alternation
    add(1,0,'h2000,1,0,'h3000,0, 0,0,'h2000,0);
    add(1,0,'h2000,1,0,'h3000,1, 1,0,'h2000,1, 1,0);
    add(0,0,'h2000,1,0,'h3000,0, 0,0,'h2000,0);
    add(0,0,'h2000,1,0,'h3000,1, 1,0,'h3000,2, 0,1);
    add(0,0,'h2000,0,0,'h3000,0, 0,0,'h2000,0);
    add(1,0,'h4000,1,0,'h5000,0, 0,0,'h4000,0);
    add(1,0,'h4000,1,0,'h5000,1, 1,0,'h4000,1, 1,0);
    add(0,0,'h4000,1,0,'h5000,0, 0,0,'h4000,0);
    add(0,0,'h4000,1,0,'h5000,1, 1,0,'h5000,2, 0,1);
    add(0,0,'h4000,0,0,'h5000,0, 0,0,'h4000,0);
    // single I-side read, ack 3 cycles after grant, then a stray ack in IDLE
    add(1,0,'h1000,0,0,0,0, 0,0,'h1000,0);
    for (int i = 0; i < 3; i++) add(1,0,'h1000,0,0,0,0, 1,0,'h1000,1);
    add(1,0,'h1000,0,0,0,1, 1,0,'h1000,1, 1,0);
    add(0,0,'h1000,0,0,0,0, 0,0,'h1000,0);
    add(0,0,'h1000,0,0,0,1, 0,0,'h1000,0);
    // m1 abort leaves rr_last=m0, so m1 wins the next contention
    add(0,0,'h1000,1,0,'h40,0, 0,0,'h1000,0);
    add(0,0,'h1000,1,0,'h40,0, 1,0,'h40,2);
    add(0,0,'h1000,1,0,'h40,0, 1,0,'h40,2);
    add(0,0,'h1000,0,0,'h40,0, 0,0,'h40,2);
    add(1,0,'h50,1,0,'h60,0, 0,0,'h50,0);
    add(1,0,'h50,1,0,'h60,0, 1,0,'h60,2);
    add(1,0,'h50,1,0,'h60,0, 1,0,'h60,2);
    add(1,0,'h50,0,0,'h60,0, 0,0,'h60,2);
    add(1,0,'h50,0,0,'h60,0, 0,0,'h50,0);
    add(1,0,'h50,0,0,'h60,1, 1,0,'h50,1, 1,0);
    add(0,0,'h50,0,0,'h60,0, 0,0,'h50,0);
    // D-side write
    add(0,0,'h50,1,1,'h20,0, 0,0,'h50,0);
    add(0,0,'h50,1,1,'h20,1, 1,1,'h20,2, 0,1);
    add(0,0,'h50,0,0,'h20,0, 0,0,'h50,0);
    // watchdog fires in the 8th grant cycle
    add(1,0,'h100,0,0,0,0, 0,0,'h100,0);
    for (int i = 0; i < 7; i++) add(1,0,'h100,0,0,0,0, 1,0,'h100,1);
    add(1,0,'h100,0,0,0,0, 1,0,'h100,1, 0,0,1,0);
    add(0,0,'h100,0,0,0,0, 0,0,'h100,0);
    // ack coincides with expiry: ack wins
    add(1,0,'h100,0,0,0,0, 0,0,'h100,0);
    for (int i = 0; i < 7; i++) add(1,0,'h100,0,0,0,0, 1,0,'h100,1);
    add(1,0,'h100,0,0,0,1, 1,0,'h100,1, 1,0,0,0);
    add(0,0,'h100,0,0,0,0, 0,0,'h100,0);
    foreach (tv[i]) begin
      drive(tv[i], i);
      #3;
      exp_dw = tv[i].eg == 2'b10 ? m1_dat_w : m0_dat_w;
      chk($sformatf("v%0d_s_cyc", i), s_cyc, tv[i].ec);
      chk($sformatf("v%0d_s_stb", i), s_stb, tv[i].ec);
      chk($sformatf("v%0d_s_we", i), s_we, tv[i].ew);
      chk($sformatf("v%0d_s_adr", i), s_adr, tv[i].ea);
      chk($sformatf("v%0d_s_dat_w", i), s_dat_w, exp_dw);
      chk($sformatf("v%0d_grant", i), grant, tv[i].eg);
      chk($sformatf("v%0d_m0_ack", i), m0_ack, tv[i].k0);
      chk($sformatf("v%0d_m1_ack", i), m1_ack, tv[i].k1);
      chk($sformatf("v%0d_m0_err", i), m0_err, tv[i].r0);
      chk($sformatf("v%0d_m1_err", i), m1_err, tv[i].r1);
      chk($sformatf("v%0d_m0_dat_r", i), m0_dat_r, {8{32'hD000_0000 | i}});
      chk($sformatf("v%0d_m1_dat_r", i), m1_dat_r, {8{32'hD000_0000 | i}});
      @(negedge clk);
    end
    // async reset while in GRANT1
    m0_cyc = 0; m0_stb = 0; m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h90; s_ack = 0;
    @(negedge clk);
    s_ack = 1;
    #1;
    chk("pre_rst_grant", grant, 2);
    chk("pre_rst_m1_ack", m1_ack, 1);
    #1 rst_n = 0;
    #1;
    chk("arst_s_cyc", s_cyc, 0);
    chk("arst_grant", grant, 0);
    chk("arst_m1_ack", m1_ack, 0);
    chk("arst_m0_ack", m0_ack, 0);
    chk("arst_m1_dat_r", m1_dat_r, 0);
    @(negedge clk);
    rst_n = 1; s_ack = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA0;
    #3;
    chk("post_rst_idle", grant, 0);
    @(negedge clk);
    #3;
    chk("post_rst_grant", grant, 1);
    chk("post_rst_s_adr", s_adr, 32'hA0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
